seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (legal range 1..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 100000, giving the clock cycles per digit slot (minimum 2).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 50, giving the full frames per blink half-period (minimum 1).
REQ-004 The block SHALL have parameter HEX_EN, default 0; 1 enables A-F glyphs, 0 blanks codes 10-15.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset; it SHALL be synchronous and active-low.
REQ-007 Port digits_in, input, 4*NUM_DIGITS bits: digit i in bits [4i+3:4i]; digit 0 is the rightmost.
REQ-008 Port dp_in, input, NUM_DIGITS bits: decimal-point request per digit.
REQ-009 Port blink_mask, input, NUM_DIGITS bits: per-digit blink enable.
REQ-010 Port blank_lz, input, 1 bit: leading-zero blanking enable (live, not snapshotted).
REQ-011 Port load, input, 1 bit: snapshot strobe for digits_in, dp_in and blink_mask.
REQ-012 Port seg_out, output, 7 bits: segments g..a, active-high, bit0 = a.
REQ-013 Port dp_out, output, 1 bit: decimal point, active-high.
REQ-014 Port an_out, output, NUM_DIGITS bits: one-hot digit enable, active-high.
REQ-015 Port frame_done, output, 1 bit: single-cycle pulse at each frame wrap.

Function
REQ-016 When load=1 at a clock edge, the block SHALL copy digits_in, dp_in and blink_mask into shadow registers; the display SHALL use only shadow values.
REQ-017 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count the scan index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-018 frame_done SHALL be 1 for exactly the one cycle after the index wraps to 0, and 0 otherwise.
REQ-019 All outputs SHALL be registered, reflecting the scan index and shadow state one cycle after they change.
REQ-020 The glyphs SHALL be gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-021 With HEX_EN=1, the glyphs SHALL be A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001; with HEX_EN=0, codes 10-15 SHALL produce seg_out=0.
REQ-022 Leading-zero blanking: with blank_lz=1, digit i>0 SHALL show seg_out=0 when its shadow code and all higher shadow codes are 0. Digit 0 is never blanked. dp_out is unaffected by this rule.
REQ-023 Blink: a frame counter SHALL toggle blink_phase every BLINK_FRAMES frame wraps. While blink_phase=1, a digit whose shadow mask bit is set SHALL drive seg_out=0 and dp_out=0, and an_out SHALL stay unchanged.
REQ-024 When load coincides with a scan advance, both SHALL take effect; the new digit SHALL display the new shadow data.
REQ-025 A load SHALL NOT restart the prescaler, the scan index or the blink phase.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL clear the prescaler, scan index, frame counter, blink_phase and all shadow registers. It SHALL also drive seg_out=0, dp_out=0, an_out=0 and frame_done=0.
REQ-027 On the first edge after rst_n returns to 1, an_out SHALL become the one-hot value for digit 0 and seg_out SHALL show glyph 0 (all-zero shadow).
REQ-028 Reset asserted mid-frame SHALL take effect at the next edge, regardless of prescaler state or a coincident load.

Structure
REQ-029 The glyph constants, the blank pattern and the $clog2-based width helpers SHALL reside in the shared package seg7_pkg.
REQ-030 Code-to-segment translation SHALL be a combinational sub-module seg7_decode (inputs: 4-bit code, hex_en; output: 7-bit segments), instantiated once on the selected digit.
REQ-031 Counter widths SHALL be $clog2(SCAN_DIV), $clog2(NUM_DIGITS) (minimum 1) and $clog2(BLINK_FRAMES+1).

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2 unless stated)
REQ-032 Reset and scan: hold rst_n=0 for 5 cycles, then release. Required: all outputs 0 during reset; an_out then goes 0001, 0010, 0100, 1000, 0001, each held 4 cycles; frame_done pulses once per 16 cycles.
REQ-033 Load decode: load=1 with digits_in=16'h1234. Required: digit 0 slot seg_out=1100110, digit 3 slot seg_out=0000110.
REQ-034 Leading-zero blanking: blank_lz=1, load 16'h0050. Required: digits 3 and 2 seg_out=0, digit 1=1101101, digit 0=0111111. Then load 16'h0000: only digit 0 lit, =0111111.
REQ-035 Hex mode: load 16'h00AF. Required with HEX_EN=0: digits 1 and 0 seg_out=0. Required with HEX_EN=1: digit 1=1110111, digit 0=1110001.
REQ-036 Blink: load blink_mask=0001, dp_in=0001, digits 16'h0008. Required: digit 0 shows seg_out=1111111 with dp_out=1 for 2 frames, then 0/0 for 2 frames, repeating; the other digits are unaffected.
REQ-037 Mid-frame reset: assert rst_n=0 at cycle 6 of a frame. Required: outputs 0 at the next edge, shadow cleared; after release, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   - Glyph patterns in gfedcba order (bit0 = segment a), active-high.
//   - SEG_BLANK: all segments off.
//   - cnt_w(): counter width helper that never returns less than 1 bit.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] GLYPH_0 = 7'b0111111;
    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] GLYPH_7 = 7'b0000111;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1101111;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b1111100;
    localparam logic [6:0] GLYPH_C = 7'b0111001;
    localparam logic [6:0] GLYPH_D = 7'b1011110;
    localparam logic [6:0] GLYPH_E = 7'b1111001;
    localparam logic [6:0] GLYPH_F = 7'b1110001;

    // $clog2 of a count range, clamped to at least one bit so that
    // single-value counters still have a legal declaration.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit code to seven-segment glyph translation.
// Ports:
//   code   - 4-bit digit code
//   hex_en - 1 enables A..F glyphs for codes 10..15, 0 blanks them
//   seg    - segments gfedcba, active-high, bit0 = a
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            4'd10:   seg = hex_en ? GLYPH_A : SEG_BLANK;
            4'd11:   seg = hex_en ? GLYPH_B : SEG_BLANK;
            4'd12:   seg = hex_en ? GLYPH_C : SEG_BLANK;
            4'd13:   seg = hex_en ? GLYPH_D : SEG_BLANK;
            4'd14:   seg = hex_en ? GLYPH_E : SEG_BLANK;
            4'd15:   seg = hex_en ? GLYPH_F : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment display driver with
// snapshot loading, leading-zero blanking and per-digit blinking.
// Ports:
//   clk        - clock, all state on rising edge
//   rst_n      - synchronous active-low reset
//   digits_in  - 4 bits per digit, digit 0 (rightmost) in [3:0]
//   dp_in      - decimal-point request per digit
//   blink_mask - per-digit blink enable
//   blank_lz   - leading-zero blanking enable (used live)
//   load       - snapshot strobe for digits_in, dp_in, blink_mask
//   seg_out    - segments gfedcba, active-high (registered)
//   dp_out     - decimal point, active-high (registered)
//   an_out     - one-hot digit enable, active-high (registered)
//   frame_done - one-cycle pulse following each frame wrap (registered)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 50,
    parameter bit HEX_EN       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int SCAN_W = cnt_w(SCAN_DIV);
    localparam int IDX_W  = cnt_w(NUM_DIGITS);
    localparam int FRM_W  = cnt_w(BLINK_FRAMES + 1);

    logic [SCAN_W-1:0]       presc;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blink;

    logic                    presc_tc;
    logic                    idx_wrap;

    logic [3:0]              code_p0;
    logic                    dp_sel_p0;
    logic                    blink_sel_p0;
    logic                    lz_p0;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   an_p0;
    logic [6:0]              glyph_p0;
    logic [6:0]              seg_p0;
    logic                    dp_p0;

    assign presc_tc = (presc == SCAN_W'(SCAN_DIV - 1));
    assign idx_wrap = presc_tc && (idx == IDX_W'(NUM_DIGITS - 1));

    // ---- stage p0: select the current digit from the shadow state ----
    // Walking from the most significant digit down accumulates "this digit
    // and everything above it is zero", which is exactly the blanking test.
    always_comb begin
        code_p0      = 4'd0;
        dp_sel_p0    = 1'b0;
        blink_sel_p0 = 1'b0;
        lz_p0        = 1'b0;
        an_p0        = '0;
        zero_above   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (sh_digits[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                code_p0      = sh_digits[4*i +: 4];
                dp_sel_p0    = sh_dp[i];
                blink_sel_p0 = sh_blink[i];
                an_p0[i]     = 1'b1;
                lz_p0        = zero_above && (i != 0);
            end
        end
    end

    seg7_decode u_decode (
        .code   (code_p0),
        .hex_en (HEX_EN),
        .seg    (glyph_p0)
    );

    // Blink blanking overrides both segments and decimal point; leading-zero
    // blanking touches segments only. The anode stays driven in both cases.
    always_comb begin
        seg_p0 = glyph_p0;
        dp_p0  = dp_sel_p0;
        if (blank_lz && lz_p0) begin
            seg_p0 = SEG_BLANK;
        end
        if (blink_phase && blink_sel_p0) begin
            seg_p0 = SEG_BLANK;
            dp_p0  = 1'b0;
        end
    end

    // ---- stage p1: counters, shadow registers and registered outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            seg_out     <= SEG_BLANK;
            dp_out      <= 1'b0;
            an_out      <= '0;
            frame_done  <= 1'b0;
        end else begin
            presc <= presc_tc ? '0 : presc + 1'b1;
            if (presc_tc) begin
                idx <= idx_wrap ? '0 : idx + 1'b1;
            end
            if (idx_wrap) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blink  <= blink_mask;
            end
            seg_out    <= seg_p0;
            dp_out     <= dp_p0;
            an_out     <= an_p0;
            frame_done <= idx_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: bench for seg7_scan_driver with a decimal-only and a
// hex-enabled instance driven from the same stimulus.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   blink_mask = '0;
    logic           blank_lz = 1'b0;
    logic           load = 1'b0;

    logic [6:0]     seg_out, seg_out_h;
    logic           dp_out, dp_out_h;
    logic [N-1:0]   an_out, an_out_h;
    logic           frame_done, frame_done_h;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .load(load),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1'b1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .load(load),
        .seg_out(seg_out_h), .dp_out(dp_out_h), .an_out(an_out_h), .frame_done(frame_done_h)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] code, input bit hex);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        if (code > 4'd9 && !hex) return 7'h00;
        return tbl[code];
    endfunction

    // Model: t counts clock edges since reset release. Outputs seen after an
    // edge describe the display position reached t edges after release, i.e.
    // slot = (t / SD) % N and completed frames = t / (SD*N).
    initial begin
        int t;
        int slot;
        int phase;
        bit zero;
        bit lzb;
        logic [3:0] m_dig [N];
        logic       m_dp  [N];
        logic       m_bl  [N];
        logic [6:0] e_seg0, e_seg1;
        logic       e_dp, e_fd;
        logic [N-1:0] e_an;
        t = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0;
                e_seg0 = '0; e_seg1 = '0; e_dp = 1'b0; e_an = '0; e_fd = 1'b0;
                for (int j = 0; j < N; j++) begin
                    m_dig[j] = '0; m_dp[j] = 1'b0; m_bl[j] = 1'b0;
                end
            end else begin
                slot  = (t / SD) % N;
                phase = ((t / (SD * N)) / BF) % 2;
                zero  = 1'b1;
                for (int j = slot; j < N; j++) if (m_dig[j] != 4'd0) zero = 1'b0;
                lzb    = blank_lz && (slot > 0) && zero;
                e_an   = '0;
                e_an[slot] = 1'b1;
                e_seg0 = lzb ? 7'h00 : glyph(m_dig[slot], 1'b0);
                e_seg1 = lzb ? 7'h00 : glyph(m_dig[slot], 1'b1);
                e_dp   = m_dp[slot];
                if (phase == 1 && m_bl[slot]) begin
                    e_seg0 = '0; e_seg1 = '0; e_dp = 1'b0;
                end
                t++;
                e_fd = ((t % (SD * N)) == 0);
                if (load) begin
                    for (int j = 0; j < N; j++) begin
                        m_dig[j] = digits_in[4*j +: 4];
                        m_dp[j]  = dp_in[j];
                        m_bl[j]  = blink_mask[j];
                    end
                end
            end
            #1;
            check("model_seg", {25'd0, seg_out}, {25'd0, e_seg0});
            check("model_seg_hex", {25'd0, seg_out_h}, {25'd0, e_seg1});
            check("model_dp", {31'd0, dp_out}, {31'd0, e_dp});
            check("model_dp_hex", {31'd0, dp_out_h}, {31'd0, e_dp});
            check("model_an", {28'd0, an_out}, {28'd0, e_an});
            check("model_an_hex", {28'd0, an_out_h}, {28'd0, e_an});
            check("model_fd", {31'd0, frame_done}, {31'd0, e_fd});
            check("model_fd_hex", {31'd0, frame_done_h}, {31'd0, e_fd});
        end
    end

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dp, input logic [N-1:0] bm);
        @(negedge clk);
        load = 1'b1; digits_in = d; dp_in = dp; blink_mask = bm;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits for the first sample of a fresh slot for digit d.
    task automatic next_slot(input int d);
        logic [N-1:0] want;
        int n;
        want = '0;
        want[d] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (an_out == want && n < 100);
        while (an_out != want && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            errors++; checks++;
            $display("FAIL slot_timeout: got an=%b expected %b", an_out, want);
        end
    endtask

    initial begin
        logic [N-1:0] cap_an [32];
        logic [6:0]   cap_seg0;
        int fd_cnt;
        bit seen_off;
        bit found;
        logic [6:0] bl_seg [5];
        logic       bl_dp  [5];

        // Reset: all outputs low for five cycles.
        repeat (5) begin
            @(negedge clk);
            check("rst_seg", {25'd0, seg_out}, 32'h0);
            check("rst_an", {28'd0, an_out}, 32'h0);
            check("rst_fd", {31'd0, frame_done}, 32'h0);
        end
        rst_n = 1'b1;

        // Scan order and frame pulse rate.
        fd_cnt = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            cap_an[c] = an_out;
            if (c == 0) cap_seg0 = seg_out;
            if (frame_done) fd_cnt++;
        end
        check("scan_c0", {28'd0, cap_an[0]}, 32'b0001);
        check("scan_seg_c0", {25'd0, cap_seg0}, 32'b0111111);
        check("scan_c3", {28'd0, cap_an[3]}, 32'b0001);
        check("scan_c4", {28'd0, cap_an[4]}, 32'b0010);
        check("scan_c8", {28'd0, cap_an[8]}, 32'b0100);
        check("scan_c12", {28'd0, cap_an[12]}, 32'b1000);
        check("scan_c16", {28'd0, cap_an[16]}, 32'b0001);
        check("fd_per_32", fd_cnt, 2);

        // Decode of 1234.
        do_load(16'h1234, 4'b0000, 4'b0000);
        next_slot(0);
        check("dec_d0", {25'd0, seg_out}, 32'b1100110);
        next_slot(3);
        check("dec_d3", {25'd0, seg_out}, 32'b0000110);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        next_slot(3);
        check("lz_d3", {25'd0, seg_out}, 32'b0);
        next_slot(2);
        check("lz_d2", {25'd0, seg_out}, 32'b0);
        next_slot(1);
        check("lz_d1", {25'd0, seg_out}, 32'b1101101);
        next_slot(0);
        check("lz_d0", {25'd0, seg_out}, 32'b0111111);
        do_load(16'h0000, 4'b0000, 4'b0000);
        next_slot(1);
        check("lz0_d1", {25'd0, seg_out}, 32'b0);
        next_slot(0);
        check("lz0_d0", {25'd0, seg_out}, 32'b0111111);

        // Hex codes on both instances.
        blank_lz = 1'b0;
        do_load(16'h00AF, 4'b0000, 4'b0000);
        next_slot(2);
        check("hex_off_d2", {25'd0, seg_out}, 32'b0111111);
        next_slot(1);
        check("hex_off_d1", {25'd0, seg_out}, 32'b0);
        check("hex_on_d1", {25'd0, seg_out_h}, 32'b1110111);
        next_slot(0);
        check("hex_off_d0", {25'd0, seg_out}, 32'b0);
        check("hex_on_d0", {25'd0, seg_out_h}, 32'b1110001);

        // Load landing on the same edge as a scan advance.
        next_slot(1);
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; digits_in = 16'h0700;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("coinc_an", {28'd0, an_out}, 32'b0100);
        check("coinc_seg", {25'd0, seg_out}, 32'b0000111);

        // Blink on digit 0: find an off->on transition, then 2 on / 2 off.
        do_load(16'h0008, 4'b0001, 4'b0001);
        seen_off = 1'b0;
        found = 1'b0;
        for (int f = 0; f < 8 && !found; f++) begin
            next_slot(0);
            if (seg_out == 7'h00) seen_off = 1'b1;
            else if (seen_off) found = 1'b1;
        end
        check("blink_found", {31'd0, found}, 32'd1);
        bl_seg[0] = seg_out; bl_dp[0] = dp_out;
        for (int f = 1; f < 5; f++) begin
            next_slot(0);
            bl_seg[f] = seg_out; bl_dp[f] = dp_out;
        end
        check("blink_f0", {24'd0, bl_dp[0], bl_seg[0]}, {24'd0, 1'b1, 7'b1111111});
        check("blink_f1", {24'd0, bl_dp[1], bl_seg[1]}, {24'd0, 1'b1, 7'b1111111});
        check("blink_f2", {24'd0, bl_dp[2], bl_seg[2]}, 32'd0);
        check("blink_f3", {24'd0, bl_dp[3], bl_seg[3]}, 32'd0);
        check("blink_f4", {24'd0, bl_dp[4], bl_seg[4]}, {24'd0, 1'b1, 7'b1111111});

        // Reset at cycle 6 of a frame with a coincident load.
        next_slot(0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0; load = 1'b1; digits_in = 16'hFFFF; dp_in = 4'hF;
        @(negedge clk);
        check("mid_rst_seg", {25'd0, seg_out}, 32'b0);
        check("mid_rst_an", {28'd0, an_out}, 32'b0);
        check("mid_rst_dp", {31'd0, dp_out}, 32'b0);
        rst_n = 1'b1; load = 1'b0;
        @(negedge clk);
        check("post_rst_an", {28'd0, an_out}, 32'b0001);
        check("post_rst_seg", {25'd0, seg_out}, 32'b0111111);
        check("post_rst_dp", {31'd0, dp_out}, 32'b0);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
